au_writeback: RTL and testbench

AU_WRITEBACK -- requirements
Module: au_writeback

---
 rtl/au_pkg.sv | 28 ++
 rtl/au_wb_fifo.sv | 50 +++++
 rtl/au_writeback.sv | 78 +++++++
 tb/tb_au_writeback.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the au datapath: opcode encoding, default width and flag bit positions.
package au_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOP0 = 3'b010;
  localparam logic [2:0] OP_NOP1 = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_RTL  = 3'b110;
  localparam logic [2:0] OP_SAR  = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic op_is_nop(input logic [2:0] op);
    return (op == OP_NOP0) || (op == OP_NOP1);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/au_wb_fifo.sv
// Two-entry in-order buffer with valid/ready on both sides and a synchronous flush.
module au_wb_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Ready depends only on registered occupancy, never on the consumer's ready.
  assign o_ready = rst_n & (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/au_writeback.sv
// Writeback stage: buffers au results for the register file and updates {N,Z,C,V} on retire.
module au_writeback #(
  parameter int unsigned DATA_W = au_pkg::DATA_W,
  parameter int unsigned RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_flags_en,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic [3:0]        flags_q
);
  import au_pkg::*;

  localparam int unsigned EntW = 3 + DATA_W + 1 + 1 + RD_W + 1;

  logic [EntW-1:0]   w_in_data;
  logic [EntW-1:0]   w_out_data;
  logic [2:0]        w_head_op;
  logic [DATA_W-1:0] w_head_res;
  logic              w_head_c;
  logic              w_head_v;
  logic [RD_W-1:0]   w_head_rd;
  logic              w_head_fe;
  logic              w_pop;
  logic [3:0]        w_flags_d;
  logic [3:0]        r_flags;

  assign w_in_data = {in_opcode, in_result, in_carry, in_overflow, in_rd, in_flags_en};
  assign {w_head_op, w_head_res, w_head_c, w_head_v, w_head_rd, w_head_fe} = w_out_data;

  au_wb_fifo #(
    .WIDTH (EntW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_data),
    .o_valid (wb_valid),
    .i_ready (wb_ready),
    .o_data  (w_out_data)
  );

  assign wb_data = w_head_res;
  assign wb_rd   = w_head_rd;
  assign w_pop   = wb_valid & wb_ready;

  // A pop completes its handshake even under flush, so flags still follow it.
  always_comb begin
    w_flags_d = r_flags;
    if (w_pop && w_head_fe && !op_is_nop(w_head_op)) begin
      w_flags_d[FLAG_N] = w_head_res[DATA_W-1];
      w_flags_d[FLAG_Z] = (w_head_res == '0);
      w_flags_d[FLAG_C] = w_head_c;
      w_flags_d[FLAG_V] = op_is_arith(w_head_op) ? w_head_v : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flags <= 4'b0000;
    else        r_flags <= w_flags_d;
  end

  assign flags_q = r_flags;

endmodule

// File: tb/tb_au_writeback.sv
// Randomized scoreboard bench for au_writeback with directed corner cases.
module tb_au_writeback;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        c;
    logic        o;
    logic [2:0]  rd;
    logic        fe;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [15:0] in_result = '0;
  logic        in_carry = 1'b0;
  logic        in_overflow = 1'b0;
  logic [2:0]  in_rd = '0;
  logic        in_flags_en = 1'b0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic [3:0]  flags_q;

  ent_t       q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] exp_flags = 4'b0000;

  au_writeback #(
    .DATA_W (16),
    .RD_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_rd       (in_rd),
    .in_flags_en (in_flags_en),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .flags_q     (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [2:0] op, input logic [15:0] res, input logic c,
                              input logic o, input logic [2:0] rd, input logic fe);
    ent_t e;
    e.op = op; e.res = res; e.c = c; e.o = o; e.rd = rd; e.fe = fe;
    return e;
  endfunction

  // Flag rules: NOPs and flags_en=0 hold; ADD/SUB take V; shifts clear V.
  function automatic logic [3:0] model_flags(input logic [3:0] f, input ent_t e);
    if (!e.fe || e.op == 3'd2 || e.op == 3'd3) return f;
    return {e.res[15], e.res == 16'h0000, e.c, (e.op <= 3'd1) ? e.o : 1'b0};
  endfunction

  task automatic drv(input ent_t e, input logic v, input logic rdy, input logic fl,
                     output logic acc);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_opcode   = e.op;
    in_result   = e.res;
    in_carry    = e.c;
    in_overflow = e.o;
    in_rd       = e.rd;
    in_flags_en = e.fe;
    wb_ready    = rdy;
    flush       = fl;
    acc = v && in_ready && !fl && rst_n;
    if (acc) q.push_back(e);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) drv(mk(3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, rdy, 1'b0, acc);
  endtask

  // Monitor: checks occupancy, head contents and flags against the scoreboard every cycle.
  always @(negedge clk) begin
    int   occ;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      exp_flags = 4'b0000;
    end else begin
      chk("flags_q", {28'h0, flags_q}, {28'h0, exp_flags});
      occ = q.size() - ((in_valid && in_ready && !flush) ? 1 : 0);
      chk("wb_valid", {31'h0, wb_valid}, {31'h0, occ > 0});
      chk("in_ready", {31'h0, in_ready}, {31'h0, occ < 2});
      if (wb_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL head: wb_valid=1 with data %0h, expected no entry", wb_data);
        end else begin
          chk("wb_data", {16'h0, wb_data}, {16'h0, q[0].res});
          chk("wb_rd", {29'h0, wb_rd}, {29'h0, q[0].rd});
          if (wb_ready) begin
            e = q.pop_front();
            exp_flags = model_flags(exp_flags, e);
          end
        end
      end
      if (flush) q.delete();
    end
  end

  initial begin
    logic acc;
    ent_t e;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_flags", {28'h0, flags_q}, 32'h0);
    chk("rst_wb_data", {16'h0, wb_data}, 32'h0);
    chk("rst_wb_rd", {29'h0, wb_rd}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD zero result with carry -> {N,Z,C,V}=0110
    drv(mk(3'd0, 16'h0000, 1'b1, 1'b0, 3'd5, 1'b1), 1'b1, 1'b1, 1'b0, acc);
    idle(3, 1'b1);
    chk("add_zero_flags", {28'h0, flags_q}, 32'h6);

    // Backpressure: third push must be held until space frees
    drv(mk(3'd1, 16'h1111, 1'b0, 1'b0, 3'd1, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drv(mk(3'd4, 16'h2222, 1'b0, 1'b0, 3'd2, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    e = mk(3'd5, 16'h3333, 1'b0, 1'b0, 3'd3, 1'b0);
    drv(e, 1'b1, 1'b0, 1'b0, acc);
    chk("third_push_held", {31'h0, acc}, 32'h0);
    for (int i = 0; i < 8 && !acc; i++) drv(e, 1'b1, 1'b1, 1'b0, acc);
    chk("third_push_accepted", {31'h0, acc}, 32'h1);
    idle(4, 1'b1);
    chk("drain_empty", q.size(), 32'h0);

    // Set flags 1011 then retire a NOP: writeback but flags hold
    drv(mk(3'd0, 16'h8001, 1'b1, 1'b1, 3'd4, 1'b1), 1'b1, 1'b1, 1'b0, acc);
    drv(mk(3'd2, 16'h0000, 1'b0, 1'b0, 3'd6, 1'b1), 1'b1, 1'b1, 1'b0, acc);
    idle(3, 1'b1);
    chk("nop_flags_hold", {28'h0, flags_q}, 32'hB);

    // Shift clears V even with overflow set
    drv(mk(3'd4, 16'h8000, 1'b1, 1'b1, 3'd7, 1'b1), 1'b1, 1'b1, 1'b0, acc);
    idle(3, 1'b1);
    chk("shl_flags", {28'h0, flags_q}, 32'hA);

    // Full buffer, flush with push and pop in the same cycle
    drv(mk(3'd1, 16'h8000, 1'b1, 1'b1, 3'd1, 1'b1), 1'b1, 1'b0, 1'b0, acc);
    drv(mk(3'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1), 1'b1, 1'b0, 1'b0, acc);
    drv(mk(3'd0, 16'h0005, 1'b0, 1'b0, 3'd3, 1'b1), 1'b1, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    chk("flush_empty", {31'h0, wb_valid}, 32'h0);
    chk("flush_pop_flags", {28'h0, flags_q}, 32'hB);
    idle(2, 1'b1);

    // Reset with two entries buffered
    drv(mk(3'd0, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b1), 1'b1, 1'b0, 1'b0, acc);
    drv(mk(3'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1), 1'b1, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("midrst_flags", {28'h0, flags_q}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4, 1'b1);
    chk("post_rst_flags", {28'h0, flags_q}, 32'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      e = mk(3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      drv(e, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, acc);
    end
    idle(4, 1'b1);
    chk("final_drain", q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
